// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: registered PC, prioritised redirect
// selection and a one-entry holding slot for redirects that arrive during a stall.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h80)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_incr,
    output logic             fetch_valid,
    output logic             flush
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Priority classes; a larger value outranks a smaller one.
    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_BR   = 2'd1;
    localparam logic [1:0] CLS_JMP  = 2'd2;
    localparam logic [1:0] CLS_EXC  = 2'd3;

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    state_t           state_r;
    logic             pend_valid_r;
    logic [WIDTH-1:0] pend_target_r;
    logic [1:0]       pend_class_r;

    logic             req_s;
    logic [1:0]       req_class_s;
    logic [WIDTH-1:0] req_target_s;
    logic             live_wins_s;

    assign pc_incr = pc + STEP_V;

    // Pick the winning live redirect and decide whether it outranks the pending one.
    always_comb begin
        req_s        = 1'b0;
        req_class_s  = CLS_NONE;
        req_target_s = {WIDTH{1'b0}};
        if (exc) begin
            req_s        = 1'b1;
            req_class_s  = CLS_EXC;
            req_target_s = EXC_VEC;
        end else if (jump) begin
            req_s        = 1'b1;
            req_class_s  = CLS_JMP;
            req_target_s = jump_target;
        end else if (branch_taken) begin
            req_s        = 1'b1;
            req_class_s  = CLS_BR;
            req_target_s = branch_target;
        end else begin
            req_s        = 1'b0;
            req_class_s  = CLS_NONE;
            req_target_s = {WIDTH{1'b0}};
        end
        live_wins_s = req_s && (!pend_valid_r || (req_class_s >= pend_class_r));
    end

    // PC register, pending-redirect slot and control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= BOOT;
            pc            <= RESET_VEC;
            fetch_valid   <= 1'b0;
            flush         <= 1'b0;
            pend_valid_r  <= 1'b0;
            pend_target_r <= {WIDTH{1'b0}};
            pend_class_r  <= CLS_NONE;
        end else begin
            case (state_r)
                BOOT: begin
                    fetch_valid <= 1'b1;
                    flush       <= 1'b0;
                    state_r     <= RUN;
                end
                RUN: begin
                    if (!stall) begin
                        if (req_s) begin
                            pc    <= req_target_s;
                            flush <= 1'b1;
                        end else begin
                            pc    <= pc_incr;
                            flush <= 1'b0;
                        end
                    end else begin
                        flush <= 1'b0;
                        if (req_s) begin
                            pend_valid_r  <= 1'b1;
                            pend_target_r <= req_target_s;
                            pend_class_r  <= req_class_s;
                            state_r       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (stall) begin
                        flush <= 1'b0;
                        if (live_wins_s) begin
                            pend_target_r <= req_target_s;
                            pend_class_r  <= req_class_s;
                        end
                    end else begin
                        pc           <= live_wins_s ? req_target_s : pend_target_r;
                        flush        <= 1'b1;
                        pend_valid_r <= 1'b0;
                        pend_class_r <= CLS_NONE;
                        state_r      <= RUN;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean boot.
                    state_r      <= BOOT;
                    pc           <= RESET_VEC;
                    fetch_valid  <= 1'b0;
                    flush        <= 1'b0;
                    pend_valid_r <= 1'b0;
                    pend_class_r <= CLS_NONE;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the instruction-fetch stage. It replaces the bare combinational PC incrementer with a registered PC and a next-PC selector. The selector handles sequential step, branch, jump and exception redirects, plus pipeline stall. A redirect that arrives while the stage is stalled is held and applied when the stall releases. The unit drives the instruction-memory address and the PC+step value carried down the IF/ID pipeline register.

## Interface
Parameters:
- WIDTH, 32, PC and target width in bits
- STEP, 1, sequential increment (1 = word-addressed memory, 4 = byte-addressed)
- RESET_VEC, 0, PC value loaded by reset
- EXC_VEC, 'h80, PC value loaded on exception

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- stall  input  1  hold PC (hazard unit); redirects arriving during stall are held pending
- branch_taken  input  1  take branch_target
- branch_target  input  WIDTH  branch destination
- jump  input  1  take jump_target
- jump_target  input  WIDTH  jump destination
- exc  input  1  take EXC_VEC
- pc  output  WIDTH  registered current PC (instruction-memory address)
- pc_incr  output  WIDTH  pc + STEP, combinational, modulo 2^WIDTH
- fetch_valid  output  1  registered; pc holds a fetchable address
- flush  output  1  registered; one-cycle pulse after a redirect is loaded, tells IF/ID to squash

## Operation
- Reset values (rst_n low, immediate): pc = RESET_VEC; fetch_valid = 0; flush = 0; pend_valid = 0; pend_target = 0; state = BOOT.
- States:
  - BOOT: first edge after rst_n rises. pc stays RESET_VEC and fetch_valid goes 1. Redirect and stall inputs are ignored for this edge. Next state RUN.
  - RUN: no redirect pending.
  - HOLD: a redirect is pending, meaning it was captured while stall = 1.
- Redirect request priority, highest first: exc (target EXC_VEC) > jump (jump_target) > branch_taken (branch_target). A request is present if any of these three is high.
- RUN, stall = 0:
  - With a request present, pc <= the winning target and flush <= 1.
  - With no request, pc <= pc + STEP and flush <= 0.
- RUN, stall = 1:
  - pc holds and flush <= 0.
  - With a request present, pend_target <= the winning target, pend_valid <= 1, and the state goes to HOLD.
- HOLD, stall = 1:
  - pc holds and flush <= 0.
  - A new request replaces the pending one only if its priority is equal or higher (exc always replaces; a branch does not replace a pending jump or exc). pend_target records the priority class it came from.
- HOLD, stall = 0:
  - With no live request, pc <= pend_target, flush <= 1, pend_valid <= 0, and the state goes to RUN.
  - A live request with priority equal or higher than the pending one wins over it: pc <= the live target. Otherwise pc <= pend_target.
  - In both cases flush <= 1, pend_valid <= 0, and the state goes to RUN.
- Arithmetic: pc + STEP wraps modulo 2^WIDTH. Targets are loaded unmodified, with no alignment masking.
- fetch_valid stays 1 from BOOT exit until the next reset. It does not drop on stall or on flush.
- Reset asserted mid-operation: all state returns to the reset values immediately and any pending redirect is lost.

## Timing
- All state updates on the rising edge of clk, except reset, which is asynchronous.
- Redirect latency:
  - Request sampled at edge N with stall = 0: pc = target after edge N, and flush is high for the cycle after edge N.
  - Stalled redirect: pc = target after the first edge with stall = 0.
- pc_incr follows pc combinationally within the same cycle.
- flush is never high for two consecutive cycles unless two separate redirects are loaded on consecutive edges.
- Inputs are sampled only at edges. Request pulses shorter than a cycle are undefined.

## Test plan
- Reset/boot:
  - Stimulus: hold rst_n low with branch_taken = 1, release, run 4 idle edges.
  - Required: pc = 0 during reset and at BOOT; then 1, 2, 3. fetch_valid = 0 until the first edge, then 1. flush is never high.
- Branch:
  - Stimulus: at pc = 5, branch_taken = 1 with branch_target = 'h40 for 1 cycle.
  - Required: pc = 'h40, flush high for exactly 1 cycle, next pc = 'h41. pc_incr = 'h41 while pc = 'h40.
- Priority:
  - Stimulus: exc, jump (target 'h100) and branch (target 'h200) all high for one cycle.
  - Required: pc = 'h80.
  - Then: jump + branch together. Required: pc = 'h100.
- Stall with pending redirect:
  - Stimulus: stall = 1 for 3 cycles at pc = 'h10. Branch to 'h30 in stall cycle 1, jump to 'h50 in stall cycle 2, branch to 'h70 in stall cycle 3.
  - Required: pc = 'h10 throughout the stall. First unstalled edge gives pc = 'h50 (the jump keeps priority), flush high for 1 cycle.
- Wrap and STEP:
  - Stimulus: WIDTH = 8, STEP = 4, branch to 'hFC, then idle.
  - Required: pc = 'hFC, then 'h00, then 'h04.
- Reset mid-HOLD:
  - Stimulus: pending jump, then assert rst_n low mid-cycle.
  - Required: pc = RESET_VEC immediately. After release, no redirect is applied and the sequence restarts from BOOT.
